mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with HI/LO result registers.
- Sits beside the ALU, downstream of the register file. It consumes RS/RT operands and serves MULT, MULTU, DIV and DIVU.
- Results are read by MFHI/MFLO. The CPU stalls PC and register writes while busy_o is high.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  start request, sampled only in IDLE
op_i  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src1_i  in  WIDTH  RS operand (multiplicand / dividend)
src2_i  in  WIDTH  RT operand (multiplier / divisor)
hi_we_i  in  1  MTHI write enable
lo_we_i  in  1  MTLO write enable
wdata_i  in  WIDTH  MTHI/MTLO write data
busy_o  out  1  operation in progress
done_o  out  1  one-cycle completion pulse
hi_o  out  WIDTH  HI register (high product / remainder)
lo_o  out  WIDTH  LO register (low product / quotient)

Behaviour:
- Reset (rst_i high at an edge; it wins over everything):
  - state IDLE; busy_o=0, done_o=0, hi_o=0, lo_o=0; counter=0.
  - Reset in mid-operation aborts: no done_o, partial result discarded.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start_i=1 latches src1_i, src2_i and op_i, then goes to CALC.
  - For signed ops, store the operand magnitudes and both sign bits.
  - start_i in any other state is ignored (no queueing).
- CALC: WIDTH cycles, counter 0..WIDTH-1.
  - Multiply: shift-add on magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle.
- FIX: one cycle.
  - Apply sign correction. Product is negated if the signs differ. Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
  - Write HI/LO, return to IDLE.
- Latency: start sampled at edge T; busy_o high for cycles T+1..T+WIDTH+1; done_o high exactly one cycle at T+WIDTH+2, with new hi_o/lo_o valid that same cycle.
- A new start_i is accepted in the done_o cycle (back-to-back operation).
- Arithmetic (all modulo 2^WIDTH per register):
  - Products are full 2*WIDTH results.
  - Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (DIV and DIVU): HI=src1 as latched, LO=all ones; sign correction skipped.
- hi_we_i/lo_we_i:
  - Honoured only when busy_o=0; HI/LO take wdata_i at the next edge. Ignored while busy.
  - If a write coincides with an accepted start, the write is applied and is later overwritten at FIX.

Optional Feature:
MDU_DIV_EN:
- Defined: full divide support as above.
- Undefined: divider datapath is not built.
  - DIV/DIVU starts go IDLE -> FIX, with done_o at T+2.
  - HI/LO are left unchanged.
  - Multiply behaviour is identical.

Decomposition:
- Package mdu_pkg holds the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state enum (IDLE, CALC, FIX) and the counter-width constant.
- One natural combinational sub-module: mdu_div_step.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new remainder and quotient bit.
  - Instantiated only under MDU_DIV_EN.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done_o exactly 34 cycles after the start edge; busy_o high 33 cycles.
- MULT 0xFFFFFFFD(-3)*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; back-to-back MULT 7*6 started in the done cycle -> LO=42, HI=0.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 5/0 -> HI=5, LO=0xFFFFFFFF.
- start_i re-asserted at cycle 5 of busy -> ignored, single done_o; rst_i at cycle 10 -> busy_o=0, HI=LO=0, no done_o.
- hi_we_i with wdata 0x1234 while idle -> hi_o=0x1234 next cycle; lo_we_i while busy -> lo_o unchanged until FIX result.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and helpers for the multiply/divide unit
// Holds the op encodings, FSM state enum and counter-width helpers used by
// mul_div_unit and mdu_div_step.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

    // Iteration counter width for an arbitrary operand width.
    function automatic int mdu_cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one restoring-division iteration
// Ports:
//   rem_i      partial remainder before this step
//   bit_i      next dividend bit shifted into the remainder
//   divisor_i  divisor magnitude
//   rem_o      partial remainder after this step
//   q_o        quotient bit produced by this step
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;

    assign shifted = {rem_i, bit_i};
    assign q_o     = (shifted >= {1'b0, divisor_i});
    // When the subtract is taken the difference is below the divisor, and when
    // it is not the shifted value is below the divisor, so WIDTH bits suffice.
    assign rem_o   = q_o ? WIDTH'(shifted - {1'b0, divisor_i}) : shifted[WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit with HI/LO registers
// Optional feature macro: MDU_DIV_EN builds the divider; without it DIV/DIVU
// complete after a single FIX cycle and leave HI/LO untouched.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, op_i         start request and operation (sampled in IDLE)
//   src1_i, src2_i        RS / RT operands
//   hi_we_i, lo_we_i      MTHI / MTLO write enables, wdata_i write data
//   busy_o, done_o        operation in progress, one-cycle completion pulse
//   hi_o, lo_o            HI / LO result registers
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int            CW   = mdu_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_e         state_q;
    mdu_op_e            op_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   opb_q;
    logic               neg1_q, neg2_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;
    logic               is_div_q;

    // Operand conditioning at start: only signed ops carry sign bits.
    logic             neg1, neg2;
    logic [WIDTH-1:0] mag1, mag2;

    assign neg1 = ~op_i[0] & src1_i[WIDTH-1];
    assign neg2 = ~op_i[0] & src2_i[WIDTH-1];
    assign mag1 = neg1 ? -src1_i : src1_i;
    assign mag2 = neg2 ? -src2_i : src2_i;

    assign is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);

    // Multiply: acc = {partial product, remaining multiplier bits}; add the
    // multiplicand when the current multiplier bit is set, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    logic [2*WIDTH-1:0] prod;
    assign prod = (neg1_q ^ neg2_q) ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
    // Divide: acc = {partial remainder, dividend bits}; quotient bits enter
    // at the bottom as dividend bits leave the top.
    logic [WIDTH-1:0] div_rem;
    logic             div_q;

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
        .bit_i     (acc_q[WIDTH-1]),
        .divisor_i (opb_q),
        .rem_o     (div_rem),
        .q_o       (div_q)
    );

    assign acc_d = is_div_q ? {div_rem, acc_q[WIDTH-2:0], div_q} : mul_next;

    // With a zero divisor every step subtracts nothing: the quotient fills with
    // ones and the remainder ends up holding the dividend magnitude, so giving
    // it the dividend sign reproduces src1 exactly.
    logic             div_by_zero;
    logic [WIDTH-1:0] div_hi, div_lo;

    assign div_by_zero = (opb_q == '0);
    assign div_lo = ((neg1_q ^ neg2_q) && !div_by_zero) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign div_hi = neg1_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`else
    assign acc_d = mul_next;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            neg1_q  <= 1'b0;
            neg2_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hi_we_i) hi_q <= wdata_i;
                    if (lo_we_i) lo_q <= wdata_i;
                    if (start_i) begin
                        op_q   <= mdu_op_e'(op_i);
                        neg1_q <= neg1;
                        neg2_q <= neg2;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (op_i[1]) begin
                            acc_q <= {{WIDTH{1'b0}}, mag1};
                            opb_q <= mag2;
                        end else begin
                            acc_q <= {{WIDTH{1'b0}}, mag2};
                            opb_q <= mag1;
                        end
`ifdef MDU_DIV_EN
                        state_q <= CALC;
`else
                        state_q <= op_i[1] ? FIX : CALC;
`endif
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= FIX;
                end
                FIX: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                    if (!is_div_q) begin
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                        lo_q <= prod[WIDTH-1:0];
                    end
`ifdef MDU_DIV_EN
                    else begin
                        hi_q <= div_hi;
                        lo_q <= div_lo;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
